// File: rtl/vbs_raster_generator.sv
// rtl/vbs_raster_generator.sv - composite-video raster engine: timing, composite sync, bitmap fetch and serialiser
// Define VBS_EQUALIZING_EN for split broad pulses and equalizing lines around vertical sync.
module vbs_raster_generator #(
  parameter int H_TOTAL       = 512,
  parameter int LINE_COUNT    = 313,
  parameter int HSYNC_LEN     = 29,
  parameter int VSYNC_LINES   = 3,
  parameter int X_START       = 96,
  parameter int Y_START       = 35,
  parameter int BYTES_PER_ROW = 40,
  parameter int ROWS          = 64,
  parameter int ROW_REPEAT    = 3,
  parameter int ADDR_W        = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              invert,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              sync,
  output logic              pixel,
  output logic              active,
  output logic              frame_start
);

  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(LINE_COUNT);
  localparam int B_W = $clog2(BYTES_PER_ROW + 1);
  localparam int R_W = $clog2(ROW_REPEAT + 1);

  localparam logic [H_W-1:0]    H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    V_LAST      = V_W'(LINE_COUNT - 1);
  localparam logic [V_W-1:0]    WIN_Y_FIRST = V_W'(Y_START);
  localparam logic [V_W-1:0]    WIN_Y_LAST  = V_W'(Y_START + ROWS * ROW_REPEAT - 1);
  // active is registered, so it is decoded one position early to line up with the shift register
  localparam logic [H_W-1:0]    ACT_X_FIRST = H_W'(X_START - 1);
  localparam logic [H_W-1:0]    ACT_X_LAST  = H_W'(X_START + 8 * BYTES_PER_ROW - 2);
  localparam logic [H_W-1:0]    SLOT_FIRST  = H_W'(X_START - 3);
  localparam logic [2:0]        SLOT_PHASE  = 3'((X_START - 3) % 8);
  localparam logic [B_W-1:0]    LAST_BYTE   = B_W'(BYTES_PER_ROW - 1);
  localparam logic [R_W-1:0]    LAST_REP    = R_W'(ROW_REPEAT - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH   = ADDR_W'(BYTES_PER_ROW);
  localparam logic [H_W-1:0]    HSYNC_END   = H_W'(HSYNC_LEN);
  localparam logic [H_W-1:0]    BROAD_END   = H_W'(H_TOTAL - HSYNC_LEN);
  localparam logic [V_W-1:0]    VSYNC_END   = V_W'(VSYNC_LINES);
`ifdef VBS_EQUALIZING_EN
  localparam logic [H_W-1:0]    HALF_LINE    = H_W'(H_TOTAL / 2);
  localparam logic [H_W-1:0]    BROAD1_END   = H_W'(H_TOTAL / 2 - HSYNC_LEN);
  localparam logic [H_W-1:0]    EQ1_END      = H_W'(HSYNC_LEN / 2);
  localparam logic [H_W-1:0]    EQ2_END      = H_W'(H_TOTAL / 2 + HSYNC_LEN / 2);
  localparam logic [V_W-1:0]    EQ_PRE_FIRST = V_W'(LINE_COUNT - VSYNC_LINES);
  localparam logic [V_W-1:0]    EQ_POST_END  = V_W'(2 * VSYNC_LINES);
`endif

  typedef enum logic [1:0] {IDLE, FETCH, TAIL} stateT;

  stateT             state;
  stateT             stateNext;
  logic [H_W-1:0]    hPos;
  logic [H_W-1:0]    hNext;
  logic [V_W-1:0]    vPos;
  logic [V_W-1:0]    vNext;
  logic [B_W-1:0]    byteIdx;
  logic [R_W-1:0]    repCnt;
  logic [ADDR_W-1:0] rowBase;
  logic              invLatched;
  logic [7:0]        shiftReg;
  logic              rdPend;

  logic lineEnd;
  logic frameWrap;
  logic frameHit;
  logic winLine;
  logic nextWinLine;
  logic slotHit;
  logic activeLevel;
  logic syncLevel;

  always_comb begin
    lineEnd     = (hPos == H_LAST);
    frameWrap   = lineEnd && (vPos == V_LAST);
    frameHit    = (hPos == '0) && (vPos == '0);
    hNext       = lineEnd ? '0 : hPos + H_W'(1);
    vNext       = vPos;
    if (lineEnd) begin
      vNext = (vPos == V_LAST) ? '0 : vPos + V_W'(1);
    end
    winLine     = (vPos >= WIN_Y_FIRST) && (vPos <= WIN_Y_LAST);
    nextWinLine = (vNext >= WIN_Y_FIRST) && (vNext <= WIN_Y_LAST);
    // fetch slots fall every 8 clocks; byteIdx moves the FSM to TAIL after the last one
    slotHit     = (state == FETCH) && (hPos >= SLOT_FIRST) && (hPos[2:0] == SLOT_PHASE);
    activeLevel = winLine && (hPos >= ACT_X_FIRST) && (hPos <= ACT_X_LAST);
  end

  always_comb begin
    syncLevel = !(hPos < HSYNC_END);
`ifdef VBS_EQUALIZING_EN
    if (vPos < VSYNC_END) begin
      syncLevel = !((hPos < BROAD1_END) || ((hPos >= HALF_LINE) && (hPos < BROAD_END)));
    end else if ((vPos >= EQ_PRE_FIRST) || ((vPos >= VSYNC_END) && (vPos < EQ_POST_END))) begin
      syncLevel = !((hPos < EQ1_END) || ((hPos >= HALF_LINE) && (hPos < EQ2_END)));
    end
`else
    if (vPos < VSYNC_END) begin
      syncLevel = !(hPos < BROAD_END);
    end
`endif
  end

  always_comb begin
    stateNext = state;
    if (frameWrap) begin
      stateNext = IDLE;
    end else if (lineEnd) begin
      stateNext = nextWinLine ? FETCH : IDLE;
    end else if (slotHit && (byteIdx == LAST_BYTE)) begin
      stateNext = TAIL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hPos        <= '0;
      vPos        <= '0;
      byteIdx     <= '0;
      repCnt      <= '0;
      rowBase     <= '0;
      invLatched  <= 1'b0;
      shiftReg    <= '0;
      rdPend      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      sync        <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hPos        <= hNext;
      vPos        <= vNext;
      sync        <= syncLevel;
      active      <= activeLevel;
      frame_start <= frameHit;
      mem_rd      <= slotHit;
      rdPend      <= mem_rd;
      if (slotHit) begin
        mem_addr <= rowBase + ADDR_W'(byteIdx);
      end
      if (lineEnd) begin
        byteIdx <= '0;
      end else if (slotHit) begin
        byteIdx <= byteIdx + B_W'(1);
      end
      // read data arrives the cycle after the strobe; otherwise shift left with zero fill
      if (rdPend) begin
        shiftReg <= mem_data;
      end else begin
        shiftReg <= {shiftReg[6:0], 1'b0};
      end
      if (frameHit) begin
        rowBase    <= base_addr;
        invLatched <= invert;
        repCnt     <= '0;
      end else if (lineEnd && winLine) begin
        if (repCnt == LAST_REP) begin
          repCnt  <= '0;
          rowBase <= rowBase + ROW_PITCH;
        end else begin
          repCnt <= repCnt + R_W'(1);
        end
      end
    end
  end

  assign pixel = active & (shiftReg[7] ^ invLatched);

endmodule

// File: tb/tb_vbs_raster_generator.sv
// tb/tb_vbs_raster_generator.sv - scoreboard bench for vbs_raster_generator on a reduced raster
module tb_vbs_raster_generator;

  localparam int H     = 128;
  localparam int LC    = 40;
  localparam int HS    = 9;
  localparam int VS    = 3;
  localparam int XS    = 24;
  localparam int YS    = 8;
  localparam int BPR   = 4;
  localparam int NROWS = 4;
  localparam int REP   = 3;
  localparam int AW    = 11;
  localparam int FRAME = H * LC;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          invert = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          sync;
  logic          pixel;
  logic          active;
  logic          frame_start;

  vbs_raster_generator #(
    .H_TOTAL(H), .LINE_COUNT(LC), .HSYNC_LEN(HS), .VSYNC_LINES(VS),
    .X_START(XS), .Y_START(YS), .BYTES_PER_ROW(BPR), .ROWS(NROWS),
    .ROW_REPEAT(REP), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr), .invert(invert),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .sync(sync), .pixel(pixel), .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {int v; int h; int val;} evT;
  evT   rdQ[$];
  evT   pxQ[$];
  evT   syncQ[$];
  int   fsQ[$];
  logic [7:0] mem [0:2047];
  int   kCnt = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   inLow = 1'b0;
  int   lowH, lowV, lowK;

  // cycles since reset release; the DUT raster position is derived from this alone
  always @(posedge clk) begin
    if (!reset_n) kCnt <= 0;
    else kCnt <= kCnt + 1;
    mem_data <= mem_rd ? mem[mem_addr] : 8'h66;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, kCnt);
    end
  endtask

  task automatic pushEv(ref evT q[$], input int v, input int h, input int val);
    evT e;
    e.v = v; e.h = h; e.val = val;
    q.push_back(e);
  endtask

  task automatic pushFrame(input int f, input int base, input bit inv);
    int a;
    logic [7:0] b;
    fsQ.push_back(f * FRAME + 1);
    for (int v = 0; v < LC; v++) begin
`ifdef VBS_EQUALIZING_EN
      if (v < VS) begin
        pushEv(syncQ, v, 1, H / 2 - HS);
        pushEv(syncQ, v, H / 2 + 1, H / 2 - HS);
      end else if (v >= LC - VS || (v >= VS && v < 2 * VS)) begin
        pushEv(syncQ, v, 1, HS / 2);
        pushEv(syncQ, v, H / 2 + 1, HS / 2);
      end else begin
        pushEv(syncQ, v, 1, HS);
      end
`else
      if (v < VS) pushEv(syncQ, v, 1, H - HS);
      else pushEv(syncQ, v, 1, HS);
`endif
      if (v >= YS && v < YS + NROWS * REP) begin
        for (int n = 0; n < BPR; n++) begin
          a = (base + ((v - YS) / REP) * BPR + n) % 2048;
          pushEv(rdQ, v, XS - 2 + 8 * n, a);
          b = mem[a];
          for (int bi = 0; bi < 8; bi++) pushEv(pxQ, v, XS + 8 * n + bi, int'(b[7 - bi] ^ inv));
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int h, v;
    evT e;
    if (!reset_n) begin
      inLow = 1'b0;
      check("rst_sync", sync, 1);
      check("rst_pixel", pixel, 0);
      check("rst_active", active, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_frame_start", frame_start, 0);
    end else begin
      h = kCnt % H;
      v = (kCnt / H) % LC;
      if (frame_start === 1'b1) begin
        if (fsQ.size() == 0) check("frame_start_extra", kCnt, -1);
        else check("frame_start_k", kCnt, fsQ.pop_front());
      end
      if (mem_rd === 1'b1) begin
        if (rdQ.size() == 0) check("mem_rd_extra", v * H + h, -1);
        else begin
          e = rdQ.pop_front();
          check("rd_line", v, e.v);
          check("rd_hpos", h, e.h);
          check("rd_addr", mem_addr, e.val);
        end
      end
      if (active === 1'b1) begin
        if (pxQ.size() == 0) check("active_extra", v * H + h, -1);
        else begin
          e = pxQ.pop_front();
          check("px_line", v, e.v);
          check("px_hpos", h, e.h);
          check("px_value", pixel, e.val);
        end
      end else begin
        check("pixel_outside", pixel, 0);
      end
      if (sync === 1'b0 && !inLow) begin
        inLow = 1'b1; lowH = h; lowV = v; lowK = kCnt;
      end else if (sync === 1'b1 && inLow) begin
        inLow = 1'b0;
        if (syncQ.size() == 0) check("sync_extra", lowV * H + lowH, -1);
        else begin
          e = syncQ.pop_front();
          check("sync_line", lowV, e.v);
          check("sync_start", lowH, e.h);
          check("sync_width", kCnt - lowK, e.val);
        end
      end
    end
  end

  task automatic waitK(input int k);
    while (kCnt < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // program the next frame while the previous one is still being displayed
  task automatic setFrame(input int f, input int base, input bit inv);
    waitK(f * FRAME - 4500);
    base_addr = AW'(base);
    invert = inv;
    pushFrame(f, base, inv);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'((a * 37) ^ 8'h3C);
    for (int a = 0; a < 16; a++) mem[11'h400 + a] = 8'h00;
    mem[0] = 8'hA5;
    base_addr = '0;
    invert = 1'b0;
    pushFrame(0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;
    setFrame(1, 11'h7FE, 1'b0);
    setFrame(2, 11'h400, 1'b1);
    setFrame(3, 11'h010, 1'b1);
    setFrame(4, 11'h020, 1'b0);
    waitK(4 * FRAME + 10 * H + 40);
    reset_n = 1'b0;
    rdQ.delete();
    pxQ.delete();
    syncQ.delete();
    fsQ.delete();
    base_addr = 11'h7F8;
    invert = 1'b0;
    pushFrame(0, 11'h7F8, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b1;
    setFrame(1, 11'h003, 1'b1);
    waitK(2 * FRAME);
    check("rd_left", rdQ.size(), 0);
    check("px_left", pxQ.size(), 0);
    check("sync_left", syncQ.size(), 0);
    check("fs_left", fsQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
